// File: rtl/wb_arb_pkg.sv
// Shared constants for the register-file write-port arbiter:
// RegDst encodings, fixed link-register numbers and the per-cycle
// arbitration reason.
package wb_arb_pkg;

  // {RegDst1,RegDst0} destination select
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R25 = 2'b10;
  localparam logic [1:0] RD_R31 = 2'b11;

  // Fixed link destinations ($t9 for jalr-style links, $ra for jal)
  localparam logic [4:0] REG_R25 = 5'd25;
  localparam logic [4:0] REG_R31 = 5'd31;

  // Why the write port is used the way it is this cycle
  typedef enum logic [2:0] {
    ARB_NONE,
    ARB_MAIN,
    ARB_DRAIN,
    ARB_HAZARD,
    ARB_FORCE
  } arb_reason_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding late multi-cycle results ({dest, data}) until the
// write port is free. Exposes the head combinationally plus every entry's
// destination and valid bit so the arbiter can detect read hazards.
module wb_result_fifo #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [REG_W-1:0]              push_dest,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [$clog2(QDEPTH+1)-1:0]   count,
  output logic                          full,
  output logic [REG_W-1:0]              head_dest,
  output logic [DATA_W-1:0]             head_data,
  output logic [QDEPTH*REG_W-1:0]       entry_dest,
  output logic [QDEPTH-1:0]             entry_valid
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH+1);

  logic [REG_W-1:0]  dest_mem [QDEPTH];
  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic [QDEPTH-1:0] valid_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents need no reset because valid bits gate their use
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_reg] <= push_dest;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Per-entry valid bits; a push into the slot being popped (full case) wins
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
        valid_reg[gi] <= 1'b0;
      end
    end
    assign entry_dest[gi*REG_W +: REG_W] = dest_mem[gi];
  end

  assign entry_valid = valid_reg;
  assign count       = count_reg;
  assign full        = (count_reg == CNT_W'(QDEPTH));
  assign head_dest   = dest_mem[rd_ptr_reg];
  assign head_data   = data_mem[rd_ptr_reg];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the single-cycle main datapath
// and the late multi-cycle (mult/div) unit. Late results queue in a FIFO;
// the arbiter stalls the PC on read hazards against queued destinations
// and forces a drain when the FIFO is full or its head has starved.
// Optional build macro: WB_BYPASS_EN (write an mc result straight through
// when the port and FIFO are idle).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              main_we,
  input  logic [1:0]        main_regdst,
  input  logic [REG_W-1:0]  main_rt,
  input  logic [REG_W-1:0]  main_rd,
  input  logic [REG_W-1:0]  main_rs,
  input  logic [DATA_W-1:0] main_wdata,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_W-1:0]  mc_dest,
  input  logic [DATA_W-1:0] mc_wdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              pending
);

  localparam int CNT_W  = $clog2(QDEPTH+1);
  localparam int WAIT_W = $clog2(STARVE_MAX) + 1;

  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_nonempty;
  logic [REG_W-1:0]        head_dest;
  logic [DATA_W-1:0]       head_data;
  logic [QDEPTH*REG_W-1:0] entry_dest;
  logic [QDEPTH-1:0]       entry_valid;
  logic [QDEPTH-1:0]       hit_vec;
  logic [REG_W-1:0]        main_dest;
  arb_reason_e             reason;
  logic                    pop;
  logic                    push;
  logic                    bypass;
  logic                    mc_ready_reg;
  logic [CNT_W-1:0]        count_next;
  logic [WAIT_W-1:0]       wait_reg;
  logic [WAIT_W-1:0]       wait_next;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_dest   (mc_dest),
    .push_data   (mc_wdata),
    .pop         (pop),
    .count       (fifo_count),
    .full        (fifo_full),
    .head_dest   (head_dest),
    .head_data   (head_data),
    .entry_dest  (entry_dest),
    .entry_valid (entry_valid)
  );

  assign fifo_nonempty = (fifo_count != '0);

  // A source read that matches any queued non-zero destination is a hazard
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_hazard
    logic [REG_W-1:0] qdest;
    assign qdest       = entry_dest[gi*REG_W +: REG_W];
    assign hit_vec[gi] = entry_valid[gi] && (qdest != '0) &&
                         ((qdest == main_rs) || (qdest == main_rt));
  end

  // Resolve the main instruction's destination from RegDst
  always_comb begin
    main_dest = main_rt;
    case (main_regdst)
      RD_RT:   main_dest = main_rt;
      RD_RD:   main_dest = main_rd;
      RD_R25:  main_dest = REG_W'(REG_R25);
      RD_R31:  main_dest = REG_W'(REG_R31);
      default: main_dest = main_rt;
    endcase
  end

  // Priority arbitration: hazard, forced drain, main retirement, idle drain
  always_comb begin
    reason = ARB_NONE;
    if (fifo_nonempty && (|hit_vec)) begin
      reason = ARB_HAZARD;
    end else if (main_we && fifo_nonempty &&
                 (fifo_full || (wait_reg == WAIT_W'(STARVE_MAX-1)))) begin
      reason = ARB_FORCE;
    end else if (main_we) begin
      reason = ARB_MAIN;
    end else if (fifo_nonempty) begin
      reason = ARB_DRAIN;
    end
  end

  // Same-cycle bypass of an mc result when nothing else wants the port
`ifdef WB_BYPASS_EN
  assign bypass = !reset && !fifo_nonempty && !main_we && mc_valid;
`else
  assign bypass = 1'b0;
`endif

  // Drive the write port and stall from the arbitration decision
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    stall    = 1'b0;
    pop      = 1'b0;
    case (reason)
      ARB_HAZARD, ARB_FORCE: begin
        stall    = 1'b1;
        pop      = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = head_dest;
        rf_wdata = head_data;
      end
      ARB_DRAIN: begin
        pop      = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = head_dest;
        rf_wdata = head_data;
      end
      ARB_MAIN: begin
        rf_we    = (main_dest != '0);
        rf_waddr = main_dest;
        rf_wdata = main_wdata;
      end
      default: begin
        if (bypass) begin
          rf_we    = (mc_dest != '0);
          rf_waddr = mc_dest;
          rf_wdata = mc_wdata;
        end
      end
    endcase
    if (reset) begin
      rf_we = 1'b0;
      stall = 1'b0;
      pop   = 1'b0;
    end
  end

  assign push       = !reset && mc_valid && mc_ready_reg && !bypass;
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign mc_ready   = !reset && (mc_ready_reg || bypass);
  assign pending    = !reset && fifo_nonempty;

  // Starvation counter: counts main cycles that bypass a waiting head
  always_comb begin
    wait_next = wait_reg;
    if (pop || !fifo_nonempty) begin
      wait_next = '0;
    end else if (reason == ARB_MAIN) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
  end

  // Registered ready (from next occupancy) and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_ready_reg <= 1'b1;
      wait_reg     <= '0;
    end else begin
      mc_ready_reg <= (count_next < CNT_W'(QDEPTH));
      wait_reg     <= wait_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default build).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        main_we;
  logic [1:0]  main_regdst;
  logic [4:0]  main_rt, main_rd, main_rs;
  logic [31:0] main_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_dest;
  logic [31:0] mc_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic        pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .main_we     (main_we),
    .main_regdst (main_regdst),
    .main_rt     (main_rt),
    .main_rd     (main_rd),
    .main_rs     (main_rs),
    .main_wdata  (main_wdata),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_dest     (mc_dest),
    .mc_wdata    (mc_wdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .stall       (stall),
    .pending     (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then log the cycle
  task automatic settle(input string step);
    #1;
    $display("[%0t] %s: rf_we=%0b waddr=%0d wdata=%0h stall=%0b ready=%0b pending=%0b",
             $time, step, rf_we, rf_waddr, rf_wdata, stall, mc_ready, pending);
  endtask

  task automatic main_op(input logic we, input logic [1:0] rdst, input logic [4:0] rd,
                         input logic [31:0] wd);
    main_we     = we;
    main_regdst = rdst;
    main_rd     = rd;
    main_wdata  = wd;
  endtask

  task automatic mc_op(input logic v, input logic [4:0] d, input logic [31:0] wd);
    mc_valid = v;
    mc_dest  = d;
    mc_wdata = wd;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    main_rt = 5'd0;
    main_rs = 5'd0;
    main_op(1'b1, 2'b01, 5'd9, 32'hA5);
    mc_op(1'b1, 5'd8, 32'h77);
    tick();
    tick();
    settle("reset");
    chk("reset_rf_we",    rf_we,    0);
    chk("reset_stall",    stall,    0);
    chk("reset_mc_ready", mc_ready, 0);
    chk("reset_pending",  pending,  0);

    // Test 1: rd destination, same-cycle write
    tick();
    reset = 1'b0;
    mc_op(1'b0, 5'd0, 32'h0);
    settle("t1 rd=9");
    chk("t1_rf_we",    rf_we,    1);
    chk("t1_waddr",    rf_waddr, 9);
    chk("t1_wdata",    rf_wdata, 32'hA5);
    chk("t1_stall",    stall,    0);
    chk("t1_mc_ready", mc_ready, 1);

    // Test 2: $25, $31, rt=0
    tick();
    main_rt = 5'd3;
    main_op(1'b1, 2'b10, 5'd4, 32'h25);
    settle("t2 regdst=10");
    chk("t2_r25_waddr", rf_waddr, 25);
    chk("t2_r25_we",    rf_we,    1);
    tick();
    main_op(1'b1, 2'b11, 5'd4, 32'h31);
    settle("t2 regdst=11");
    chk("t2_r31_waddr", rf_waddr, 31);
    tick();
    main_rt = 5'd0;
    main_op(1'b1, 2'b00, 5'd4, 32'h11);
    settle("t2 rt=0");
    chk("t2_r0_we",    rf_we, 0);
    chk("t2_r0_stall", stall, 0);

    // Test 3: mc push under 3 busy main cycles, drained on the first idle one
    tick();
    main_op(1'b1, 2'b01, 5'd10, 32'h1);
    mc_op(1'b1, 5'd8, 32'h77);
    settle("t3 push 8");
    chk("t3a_waddr",   rf_waddr, 10);
    chk("t3a_ready",   mc_ready, 1);
    chk("t3a_pending", pending,  0);
    tick();
    mc_op(1'b0, 5'd0, 32'h0);
    main_op(1'b1, 2'b01, 5'd11, 32'h2);
    settle("t3 main 11");
    chk("t3b_pending", pending,  1);
    chk("t3b_waddr",   rf_waddr, 11);
    chk("t3b_stall",   stall,    0);
    tick();
    main_op(1'b1, 2'b01, 5'd12, 32'h3);
    settle("t3 main 12");
    chk("t3c_waddr", rf_waddr, 12);
    chk("t3c_stall", stall,    0);
    tick();
    main_op(1'b0, 2'b01, 5'd0, 32'h0);
    settle("t3 idle drain");
    chk("t3d_we",      rf_we,    1);
    chk("t3d_waddr",   rf_waddr, 8);
    chk("t3d_wdata",   rf_wdata, 32'h77);
    chk("t3d_stall",   stall,    0);
    tick();
    settle("t3 after drain");
    chk("t3e_pending", pending, 0);
    chk("t3e_we",      rf_we,   0);

    // Test 4: read hazard on a queued destination
    tick();
    mc_op(1'b1, 5'd8, 32'h88);
    settle("t4 push 8");
    chk("t4a_we", rf_we, 0);
    tick();
    mc_op(1'b0, 5'd0, 32'h0);
    main_rs = 5'd8;
    main_op(1'b1, 2'b01, 5'd13, 32'h13);
    settle("t4 hazard");
    chk("t4b_stall", stall,    1);
    chk("t4b_waddr", rf_waddr, 8);
    chk("t4b_wdata", rf_wdata, 32'h88);
    tick();
    settle("t4 main retires");
    chk("t4c_stall",   stall,    0);
    chk("t4c_waddr",   rf_waddr, 13);
    chk("t4c_wdata",   rf_wdata, 32'h13);
    chk("t4c_pending", pending,  0);
    main_rs = 5'd0;

    // Test 5: full FIFO forces a drain, then starvation forces the next
    tick();
    main_op(1'b1, 2'b01, 5'd14, 32'h14);
    mc_op(1'b1, 5'd5, 32'h55);
    settle("t5 push 5");
    chk("t5a_waddr", rf_waddr, 14);
    chk("t5a_ready", mc_ready, 1);
    tick();
    main_op(1'b1, 2'b01, 5'd15, 32'h15);
    mc_op(1'b1, 5'd6, 32'h66);
    settle("t5 push 6");
    chk("t5b_waddr", rf_waddr, 15);
    chk("t5b_ready", mc_ready, 1);
    chk("t5b_stall", stall,    0);
    tick();
    mc_op(1'b0, 5'd0, 32'h0);
    main_op(1'b1, 2'b01, 5'd16, 32'h16);
    settle("t5 full force");
    chk("t5c_ready", mc_ready, 0);
    chk("t5c_stall", stall,    1);
    chk("t5c_waddr", rf_waddr, 5);
    chk("t5c_wdata", rf_wdata, 32'h55);
    tick();
    settle("t5 main 16");
    chk("t5d_stall", stall,    0);
    chk("t5d_waddr", rf_waddr, 16);
    tick();
    main_op(1'b1, 2'b01, 5'd17, 32'h17);
    settle("t5 main 17");
    chk("t5e_stall", stall, 0);
    tick();
    main_op(1'b1, 2'b01, 5'd18, 32'h18);
    settle("t5 main 18");
    chk("t5f_stall", stall, 0);
    chk("t5f_waddr", rf_waddr, 18);
    tick();
    settle("t5 starve force");
    chk("t5g_stall", stall,    1);
    chk("t5g_waddr", rf_waddr, 6);
    chk("t5g_wdata", rf_wdata, 32'h66);
    tick();
    settle("t5 main 18 retry");
    chk("t5h_stall",   stall,    0);
    chk("t5h_waddr",   rf_waddr, 18);
    chk("t5h_pending", pending,  0);

    // Test 6: reset with two queued entries discards them
    tick();
    main_op(1'b1, 2'b01, 5'd20, 32'h20);
    mc_op(1'b1, 5'd9, 32'h99);
    settle("t6 push 9");
    chk("t6a_waddr", rf_waddr, 20);
    tick();
    main_op(1'b1, 2'b01, 5'd21, 32'h21);
    mc_op(1'b1, 5'd10, 32'hAA);
    settle("t6 push 10");
    chk("t6b_pending", pending, 1);
    tick();
    reset = 1'b1;
    main_op(1'b0, 2'b01, 5'd0, 32'h0);
    mc_op(1'b0, 5'd0, 32'h0);
    settle("t6 reset");
    chk("t6c_we",    rf_we, 0);
    chk("t6c_stall", stall, 0);
    tick();
    reset = 1'b0;
    settle("t6 after reset");
    chk("t6d_pending", pending,  0);
    chk("t6d_we",      rf_we,    0);
    chk("t6d_ready",   mc_ready, 1);
    tick();
    settle("t6 idle");
    chk("t6e_we",      rf_we,   0);
    chk("t6e_pending", pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
